// File: rtl/med_ctrl.sv
// Sequencer for the MED compare/shift cell: loads a P-sample burst, runs the bubble pass schedule, captures the median.
// Latency first sample -> DSO is P + N*P - N + 1 cycles (50 for P=9); samples offered while BUSY are dropped and flagged in ERR.
module med_ctrl #(
   parameter int W = 8,
   parameter int P = 9
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         DSI,
   input  logic         ERR_CLR,
   input  logic [W-1:0] CELL_DO,
   output logic         CELL_DSI,
   output logic         CELL_BYP,
   output logic         BUSY,
   output logic         DSO,
   output logic [W-1:0] DO,
   output logic         ERR
);

   localparam int N  = (P + 1) / 2;
   localparam int CW = $clog2(P) + 1;

   localparam logic [CW-1:0] LD_LAST   = CW'(P - 1);
   localparam logic [CW-1:0] CMP_LAST0 = CW'(P - 2);
   localparam logic [CW-1:0] PASS_LAST = CW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CMP,
      S_BYPS,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  ld_q, ld_d;
   logic [CW-1:0]  pass_q, pass_d;
   logic [CW-1:0]  cyc_q, cyc_d;
   logic           dso_q, dso_d;
   logic [W-1:0]   do_q, do_d;
   logic           err_q, err_d;
   logic           err_set;
   logic           busy;

   assign busy     = (state_q == S_CMP) || (state_q == S_BYPS) || (state_q == S_DONE);
   assign CELL_DSI = DSI && ((state_q == S_IDLE) || (state_q == S_LOAD));
   assign CELL_BYP = (state_q != S_CMP);
   assign BUSY     = busy;
   assign DSO      = dso_q;
   assign DO       = do_q;
   assign ERR      = err_q;

   always_comb begin
      state_d = state_q;
      ld_d    = ld_q;
      pass_d  = pass_q;
      cyc_d   = cyc_q;
      do_d    = do_q;
      dso_d   = 1'b0;
      err_set = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (DSI) begin
               state_d = S_LOAD;
               ld_d    = CW'(1);
            end
         end
         S_LOAD: begin
            if (!DSI) begin
               err_set = 1'b1;
               state_d = S_IDLE;
               ld_d    = '0;
            end else if (ld_q == LD_LAST) begin
               state_d = S_CMP;
               ld_d    = '0;
               pass_d  = '0;
               cyc_d   = '0;
            end else begin
               ld_d = ld_q + CW'(1);
            end
         end
         // Pass k compares P-1-k pairs; the last pass skips its bypass tail.
         S_CMP: begin
            if (cyc_q == CMP_LAST0 - pass_q) begin
               cyc_d   = '0;
               state_d = (pass_q == PASS_LAST) ? S_DONE : S_BYPS;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         S_BYPS: begin
            if (cyc_q == pass_q) begin
               state_d = S_CMP;
               cyc_d   = '0;
               pass_d  = pass_q + CW'(1);
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         S_DONE: begin
            do_d    = CELL_DO;
            dso_d   = 1'b1;
            pass_d  = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (busy && DSI) begin
         err_set = 1'b1;
      end
      err_d = err_set || (err_q && !ERR_CLR);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         ld_q    <= '0;
         pass_q  <= '0;
         cyc_q   <= '0;
         dso_q   <= 1'b0;
         do_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ld_q    <= ld_d;
         pass_q  <= pass_d;
         cyc_q   <= cyc_d;
         dso_q   <= dso_d;
         do_q    <= do_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/med_ctrl.md
Name: med_ctrl

Overview:
- Sequencer that drives the MED compare/shift sort cell (ports DI, DSI, BYP, CLK, DO) to produce the median of a P-sample window.
- Accepts a contiguous burst of P samples from the pixel stream and gates them into the cell.
- Runs the fixed compare/bypass pass schedule, then captures the median from the cell's DO and presents it with a one-cycle DSO strobe.
- Sits between the window-gathering logic and the MED cell; the top-level median filter wraps med_ctrl and MED.

Parameters:
- W, 8, sample width in bits.
- P, 9, window size; must be odd and at least 3; must match the MED cell's P.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- DSI  in  1  upstream sample strobe; sample on the cell's DI is valid this cycle.
- ERR_CLR  in  1  synchronous clear of ERR.
- CELL_DO  in  W  DO output of the MED cell.
- CELL_DSI  out  1  DSI to the MED cell.
- CELL_BYP  out  1  BYP to the MED cell.
- BUSY  out  1  high while sorting; new samples are refused.
- DSO  out  1  one-cycle strobe; DO holds a new median.
- DO  out  W  captured median.
- ERR  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: IDLE state, BUSY=0, DSO=0, DO=0, ERR=0, all counters 0.
- Asynchronous assert, synchronous deassert from the system's perspective.
- Reset mid-operation aborts the window. No DSO is produced for the aborted window.
- States: IDLE, LOAD, CMP, BYPS, DONE.
- CELL_DSI = DSI when state is IDLE or LOAD, else 0. This is the only combinational path.
- CELL_BYP is 1 in IDLE, LOAD, BYPS and DONE, and 0 in CMP. It is decoded from registered state.
- Cycle numbering: cycle 0 is the first IDLE cycle with DSI=1.
- IDLE: DSI=1 moves to LOAD with the load counter set to 1. This is cycle 0, and the sample is accepted.
- LOAD (cycles 1..P-1): each cycle requires DSI=1.
  - A DSI=0 gap aborts the window: ERR is set and the block returns to IDLE.
  - After P accepted samples, the block moves to CMP with pass k=0.
- Sort schedule: N=(P+1)/2 passes. Pass k (0..N-1) consists of:
  - P-1-k cycles in CMP;
  - then k+1 cycles in BYPS, omitted for the last pass.
  - For P=9 the CMP/BYPS lengths are 8/1, 7/2, 6/3, 5/4, then 4/0.
- Pass and cycle counters are sized $clog2(P)+1.
- After the last CMP cycle, the block enters DONE for one cycle. In DONE, DO <= CELL_DO.
- Transitions to IDLE on the same edge; DSO=1 for exactly the following cycle.
- P=9 timing: load in cycles 0..8, CMP/BYPS in cycles 9..48, DONE in cycle 49, DSO=1 in cycle 50.
- Latency from the first sample to DSO is P + N·P − (N−1) − 1 + 1 cycles; this equals 50 for P=9.
- BUSY=1 in CMP, BYPS and DONE.
- DSI=1 while BUSY: the sample is dropped, CELL_DSI stays 0, ERR is set, and the schedule continues unaffected.
- A new window may start in the cycle DSO is high (back-to-back operation). DO holds its value until the next capture.
- ERR is sticky until ERR_CLR=1. If ERR_CLR and a new error occur in the same cycle, set wins.
- No arithmetic on sample data. Comparisons are done by the cell; DO is a plain W-bit register.

Test Plan:
- Bench instantiates med_ctrl with a MED cell (W=8, P=9), nRST low for 3 cycles.
- Window 5,3,9,1,7,2,8,6,4 on consecutive cycles -> CELL_BYP=0 exactly during cycles 9–16, 18–24, 27–32, 36–40, 45–48; DSO=1 only in cycle 50; DO=5; ERR=0.
- Windows all 0xAA, and 0xFF,0x00,0xFF,0x00,0xFF,0x00,0xFF,0x00,0x80 -> DO=0xAA and DO=0x80 respectively.
- Second window starting in the DSO cycle (values 10..18) -> second DSO 50 cycles later, DO=14; first DO=5 held until then.
- DSI pulsed in cycle 20 during sorting -> ERR=1 from cycle 21; DO=5 unaffected. ERR_CLR pulse -> ERR=0 next cycle. ERR_CLR coincident with a new busy DSI -> ERR stays 1.
- DSI gap at cycle 4 of load -> ERR=1, return to IDLE, no DSO; the next full window yields the correct median.
- nRST asserted in cycle 30 -> BUSY, DSO and DO go to 0 immediately; after release the next window completes normally.
